// File: rtl/bsg_clk_dly_cal_ctrl.sv
// SAR calibration of the oscillator control code against a target div_clk edge count.
// Define BSG_CLK_DLY_CAL_TRACK_EN to keep re-measuring and nudging the code after lock.
module bsg_clk_dly_cal_ctrl #(
   parameter int ctl_width_p   = 8,
   parameter int window_p      = 1024,
   parameter int settle_p      = 64,
   parameter int count_width_p = 11,
   parameter int tol_p         = 2
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     start_i,
   input  logic [count_width_p-1:0] target_i,
   input  logic                     div_clk_i,
   output logic [ctl_width_p-1:0]   ctl_o,
   output logic                     ctl_v_o,
   input  logic                     ctl_ready_i,
   output logic [count_width_p-1:0] count_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     locked_o
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_PROG    = 4'd1;
   localparam logic [3:0] S_SETTLE  = 4'd2;
   localparam logic [3:0] S_MEAS    = 4'd3;
   localparam logic [3:0] S_DECIDE  = 4'd4;
   localparam logic [3:0] S_VPROG   = 4'd5;
   localparam logic [3:0] S_VSETTLE = 4'd6;
   localparam logic [3:0] S_VMEAS   = 4'd7;
   localparam logic [3:0] S_DONE    = 4'd8;

   localparam int tmr_max_lp = (window_p > settle_p) ? window_p : settle_p;
   localparam int tmr_w_lp   = $clog2(tmr_max_lp + 1);
   localparam int bit_w_lp   = (ctl_width_p > 1) ? $clog2(ctl_width_p) : 1;
   localparam int cw1_lp     = count_width_p + 1;
   localparam logic [ctl_width_p-1:0] one_lp = ctl_width_p'(1);

   logic [3:0]               state_q, state_d;
   logic [ctl_width_p-1:0]   code_q, code_d;
   logic [bit_w_lp-1:0]      bit_q, bit_d;
   logic [count_width_p-1:0] target_q, target_d;
   logic [tmr_w_lp-1:0]      tmr_q, tmr_d;
   logic [count_width_p-1:0] meas_q, meas_d;
   logic [count_width_p-1:0] count_q, count_d;
   logic                     done_q, done_d;
   logic                     locked_q, locked_d;
   logic                     sync1_q, sync2_q, sync3_q;
`ifdef BSG_CLK_DLY_CAL_TRACK_EN
   logic                     trk_q, trk_d;
`endif

   logic                     edge_pulse;
   logic [count_width_p-1:0] meas_inc;
   logic [cw1_lp-1:0]        cnt_w, tgt_w, diff_w;

   assign edge_pulse = sync2_q & ~sync3_q;
   assign meas_inc   = (edge_pulse && (meas_q != {count_width_p{1'b1}})) ?
                       meas_q + count_width_p'(1) : meas_q;
   // Widened by one bit so the distance to target cannot wrap.
   assign cnt_w  = {1'b0, meas_inc};
   assign tgt_w  = {1'b0, target_q};
   assign diff_w = (cnt_w >= tgt_w) ? (cnt_w - tgt_w) : (tgt_w - cnt_w);

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      bit_d    = bit_q;
      target_d = target_q;
      tmr_d    = tmr_q;
      meas_d   = meas_q;
      count_d  = count_q;
      done_d   = done_q;
      locked_d = locked_q;
`ifdef BSG_CLK_DLY_CAL_TRACK_EN
      trk_d    = trk_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               target_d = target_i;
               code_d   = one_lp << (ctl_width_p - 1);
               bit_d    = bit_w_lp'(ctl_width_p - 1);
               done_d   = 1'b0;
               locked_d = 1'b0;
               state_d  = S_PROG;
`ifdef BSG_CLK_DLY_CAL_TRACK_EN
               trk_d    = 1'b0;
            end else if (state_q == S_DONE) begin
               trk_d    = 1'b1;
               tmr_d    = '0;
               state_d  = S_VSETTLE;
`endif
            end
         end
         S_PROG, S_VPROG: begin
            if (ctl_ready_i) begin
               tmr_d   = '0;
               state_d = (state_q == S_PROG) ? S_SETTLE : S_VSETTLE;
            end
         end
         S_SETTLE, S_VSETTLE: begin
            tmr_d = tmr_q + tmr_w_lp'(1);
            if (tmr_q == tmr_w_lp'(settle_p - 1)) begin
               tmr_d   = '0;
               meas_d  = '0;
               state_d = (state_q == S_SETTLE) ? S_MEAS : S_VMEAS;
            end
         end
         S_MEAS, S_VMEAS: begin
            tmr_d  = tmr_q + tmr_w_lp'(1);
            meas_d = meas_inc;
            if (tmr_q == tmr_w_lp'(window_p - 1)) begin
               count_d = meas_inc;
               if (state_q == S_MEAS) begin
                  state_d = S_DECIDE;
               end else begin
                  locked_d = (diff_w <= cw1_lp'(tol_p));
                  done_d   = 1'b1;
                  state_d  = S_DONE;
`ifdef BSG_CLK_DLY_CAL_TRACK_EN
                  if (trk_q) begin
                     tmr_d   = '0;
                     state_d = S_VSETTLE;
                     if ((cnt_w > tgt_w + cw1_lp'(tol_p)) && (code_q != {ctl_width_p{1'b1}})) begin
                        code_d  = code_q + one_lp;
                        state_d = S_VPROG;
                     end else if ((cnt_w + cw1_lp'(tol_p) < tgt_w) && (code_q != '0)) begin
                        code_d  = code_q - one_lp;
                        state_d = S_VPROG;
                     end
                  end
`endif
               end
            end
         end
         S_DECIDE: begin
            // Larger code means slower clock: keep the bit only if still too fast.
            if (!(count_q > target_q)) code_d = code_q & ~(one_lp << bit_q);
            if (bit_q == '0) begin
               state_d = S_VPROG;
            end else begin
               code_d  = code_d | (one_lp << (bit_q - bit_w_lp'(1)));
               bit_d   = bit_q - bit_w_lp'(1);
               state_d = S_PROG;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         code_q   <= '0;
         bit_q    <= '0;
         target_q <= '0;
         tmr_q    <= '0;
         meas_q   <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
         locked_q <= 1'b0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         sync3_q  <= 1'b0;
`ifdef BSG_CLK_DLY_CAL_TRACK_EN
         trk_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         bit_q    <= bit_d;
         target_q <= target_d;
         tmr_q    <= tmr_d;
         meas_q   <= meas_d;
         count_q  <= count_d;
         done_q   <= done_d;
         locked_q <= locked_d;
         sync1_q  <= div_clk_i;
         sync2_q  <= sync1_q;
         sync3_q  <= sync2_q;
`ifdef BSG_CLK_DLY_CAL_TRACK_EN
         trk_q    <= trk_d;
`endif
      end
   end

   assign ctl_o    = code_q;
   assign ctl_v_o  = (state_q == S_PROG) || (state_q == S_VPROG);
   assign count_o  = count_q;
   assign busy_o   = (state_q != S_IDLE) && (state_q != S_DONE) && !done_q;
   assign done_o   = done_q;
   assign locked_o = locked_q;

endmodule

// File: tb/tb_bsg_clk_dly_cal_ctrl.sv
// Bench for bsg_clk_dly_cal_ctrl: vector table of calibrations against an oscillator model,
// plus reset, backpressure, window-boundary and saturation sequences.
module tb_bsg_clk_dly_cal_ctrl;
   localparam int S  = 16;
   localparam int W  = 300;
   localparam int SW = 600;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_i, start_i, div_clk_i, ctl_v_o, ctl_ready_i, busy_o, done_o, locked_o;
   logic [10:0] target_i, count_o;
   logic [7:0]  ctl_o;

   logic       s_start, s_div, s_v, s_busy, s_done, s_locked;
   logic       s_ready = 1'b1;
   logic [7:0] s_target, s_count, s_ctl;

   bsg_clk_dly_cal_ctrl #(.ctl_width_p(8), .window_p(W), .settle_p(S), .count_width_p(11), .tol_p(2)) u_dut (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .target_i(target_i), .div_clk_i(div_clk_i),
      .ctl_o(ctl_o), .ctl_v_o(ctl_v_o), .ctl_ready_i(ctl_ready_i), .count_o(count_o),
      .busy_o(busy_o), .done_o(done_o), .locked_o(locked_o));

   bsg_clk_dly_cal_ctrl #(.ctl_width_p(8), .window_p(SW), .settle_p(S), .count_width_p(8), .tol_p(2)) u_sat (
      .clk_i(clk), .reset_i(reset_i), .start_i(s_start), .target_i(s_target), .div_clk_i(s_div),
      .ctl_o(s_ctl), .ctl_v_o(s_v), .ctl_ready_i(s_ready), .count_o(s_count),
      .busy_o(s_busy), .done_o(s_done), .locked_o(s_locked));

   int n_chk = 0, n_fail = 0;
   task automatic check(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Oscillator model: edges per window fall as the code rises; mode 1 = boundary pulses only.
   function automatic int model_cnt(int code, int m);
      return (m != 0) ? 1 : (255 - code) / 2;
   endfunction

   function automatic int sar(int target, int m);
      int code = 0;
      for (int b = 7; b >= 0; b--)
         if (model_cnt(code | (1 << b), m) > target) code = code | (1 << b);
      return code;
   endfunction

   typedef struct {
      int target; int mode; int bp; int ign;
      int exp_code; int exp_cnt; int exp_lock;
   } vec_t;

   function automatic vec_t mk(int t, int m, int b, int g);
      vec_t v;
      int d;
      v.target = t; v.mode = m; v.bp = b; v.ign = g;
      v.exp_code = sar(t, m);
      v.exp_cnt  = model_cnt(v.exp_code, m);
      d = v.exp_cnt - t;
      if (d < 0) d = -d;
      v.exp_lock = (d <= 2) ? 1 : 0;
      return v;
   endfunction

   // Div-clock injector: after each accepted transfer, places rising edges relative to the
   // settle/measure windows (pulse seen by the counter two cycles after the pin rises).
   int mode = 0;
   int xfer_codes[$];
   task automatic inject(int n, int m);
      if (m != 0) begin
         repeat (S - 2) @(negedge clk);
         div_clk_i = 1'b1; @(negedge clk); div_clk_i = 1'b0;
         repeat (W - 1) @(negedge clk);
         div_clk_i = 1'b1; @(negedge clk); div_clk_i = 1'b0;
      end else begin
         repeat (S + 8) @(negedge clk);
         for (int i = 0; i < n; i++) begin
            div_clk_i = 1'b1; @(negedge clk);
            div_clk_i = 1'b0; @(negedge clk);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset_i && ctl_v_o && ctl_ready_i) begin
         xfer_codes.push_back(int'(ctl_o));
         inject(model_cnt(int'(ctl_o), mode), mode);
      end
   end

   int bp = 0, wcnt = 0;
   always @(posedge clk) begin
      #1;
      if (bp == 0) ctl_ready_i = 1'b1;
      else if (ctl_v_o) begin
         wcnt++;
         ctl_ready_i = (wcnt > 20);
      end else begin
         wcnt = 0;
         ctl_ready_i = 1'b0;
      end
   end

   logic       pv = 1'b0;
   logic [7:0] po = '0;
   always @(negedge clk) begin
      if (!reset_i && ctl_v_o && pv) check("ctl_stable", int'(ctl_o), int'(po));
      pv = ctl_v_o;
      po = ctl_o;
   end

   always @(negedge clk) s_div = ~s_div;

   bit sat_fin = 0;
   initial begin
      int k;
      s_start = 1'b0; s_target = '0; s_div = 1'b0;
      @(negedge reset_i);
      @(posedge clk); #1;
      s_start = 1'b1; s_target = 8'd255;
      @(posedge clk); #1;
      s_start = 1'b0; s_target = 8'd3;
      k = 0;
      while (!s_done && k < 8000) begin @(negedge clk); k++; end
      check("sat_done", int'(s_done), 1);
      check("sat_count", int'(s_count), 255);
      check("sat_code", int'(s_ctl), 0);
      check("sat_locked", int'(s_locked), 1);
      sat_fin = 1;
   end

   task automatic start_cal(int t);
      @(posedge clk); #1;
      start_i = 1'b1; target_i = 11'(t);
      @(posedge clk); #1;
      start_i = 1'b0; target_i = 11'($urandom_range(0, 2047));
   endtask

   vec_t vecs[9];
   initial begin
      int k, code, exp_trial;
      reset_i = 1'b1; start_i = 1'b0; target_i = '0; div_clk_i = 1'b0; ctl_ready_i = 1'b1;
      vecs[0] = mk(100, 0, 0, 0);
      vecs[1] = mk(0, 0, 0, 0);
      vecs[2] = mk(127, 0, 0, 0);
      vecs[3] = mk(200, 0, 0, 0);
      vecs[4] = mk(int'($urandom_range(0, 130)), 0, 0, 0);
      vecs[5] = mk(int'($urandom_range(0, 130)), 0, 0, 0);
      vecs[6] = mk(0, 1, 0, 0);
      vecs[7] = mk(60, 0, 1, 0);
      vecs[8] = mk(80, 0, 0, 1);
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b0;
      @(negedge clk);
      check("rst_ctl", int'(ctl_o), 0);
      check("rst_v", int'(ctl_v_o), 0);
      check("rst_count", int'(count_o), 0);
      check("rst_busy", int'(busy_o), 0);
      check("rst_done", int'(done_o), 0);
      check("rst_locked", int'(locked_o), 0);

      for (int v = 0; v < 9; v++) begin
         mode = vecs[v].mode;
         bp = vecs[v].bp;
         xfer_codes.delete();
         start_cal(vecs[v].target);
         @(negedge clk);
         check("start_busy", int'(busy_o), 1);
         check("start_done", int'(done_o), 0);
         if (vecs[v].ign != 0) begin
            repeat (400) @(posedge clk);
            #1 start_i = 1'b1; target_i = 11'd5;
            @(posedge clk); #1 start_i = 1'b0;
         end
         k = 0;
         while (!done_o && k < 8000) begin @(negedge clk); k++; end
         check("done", int'(done_o), 1);
         check("busy_end", int'(busy_o), 0);
         check("final_code", int'(ctl_o), vecs[v].exp_code);
         check("final_count", int'(count_o), vecs[v].exp_cnt);
         check("locked", int'(locked_o), vecs[v].exp_lock);
         check("n_xfers", xfer_codes.size(), 9);
         code = 0;
         for (int b = 7; b >= 0; b--) begin
            exp_trial = code | (1 << b);
            if (7 - b < xfer_codes.size()) check("trial_code", xfer_codes[7 - b], exp_trial);
            if (model_cnt(exp_trial, mode) > vecs[v].target) code = exp_trial;
         end
         if (xfer_codes.size() > 8) check("verify_code", xfer_codes[8], code);
      end
      bp = 0;
      mode = 0;

      // Abort in the middle of the first measurement window.
      xfer_codes.delete();
      start_cal(100);
      k = 0;
      while (xfer_codes.size() == 0 && k < 200) begin @(negedge clk); k++; end
      check("rst_test_xfer", xfer_codes.size(), 1);
      repeat (S + 100) @(posedge clk);
      #1 reset_i = 1'b1;
      @(posedge clk); #1 reset_i = 1'b0;
      @(negedge clk);
      check("midrst_ctl", int'(ctl_o), 0);
      check("midrst_v", int'(ctl_v_o), 0);
      check("midrst_count", int'(count_o), 0);
      check("midrst_busy", int'(busy_o), 0);
      check("midrst_done", int'(done_o), 0);
      check("midrst_locked", int'(locked_o), 0);
      repeat (5) @(negedge clk);
      check("idle_stays", int'(busy_o), 0);
      repeat (W) @(posedge clk);

      k = 0;
      while (!sat_fin && k < 20000) begin @(negedge clk); k++; end
      check("sat_finished", int'(sat_fin), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
